// File: rtl/freq_counter_mc.sv
// Multi-channel reciprocal frequency counter with Schmitt-trigger edge
// detection, edge timeout and transparent AXI-Stream passthrough.
module freq_counter_mc #(
   parameter int NCH         = 2,
   parameter int ADC_WIDTH   = 14,
   parameter int LANE_WIDTH  = 16,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NCH*LANE_WIDTH-1:0]    s_axis_tdata,
   input  logic                         s_axis_tvalid,
   output logic [NCH*LANE_WIDTH-1:0]    m_axis_tdata,
   output logic                         m_axis_tvalid,
   input  logic [NCH-1:0]               cfg_enable,
   input  logic                         cfg_restart,
   input  logic                         cfg_edge,
   input  logic [ADC_WIDTH-1:0]         cfg_hi_thr,
   input  logic [ADC_WIDTH-1:0]         cfg_lo_thr,
   input  logic [COUNT_WIDTH-1:0]       cfg_ncycles,
   input  logic [COUNT_WIDTH-1:0]       cfg_timeout,
   output logic [NCH*COUNT_WIDTH-1:0]   period_count,
   output logic [NCH-1:0]               period_valid,
   output logic [NCH-1:0]               timeout_pulse,
   output logic [NCH-1:0]               saturated
);

   localparam int CW = COUNT_WIDTH;
   localparam logic [CW-1:0] CMAX = '1;
   localparam logic [CW-1:0] CONE = CW'(1);

   typedef enum logic {IDLE, MEASURE} state_t;

   logic [CW-1:0] nmax;

   assign m_axis_tdata  = s_axis_tdata;
   assign m_axis_tvalid = s_axis_tvalid;

   assign nmax = (cfg_ncycles == '0) ? CONE : cfg_ncycles;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic signed [ADC_WIDTH-1:0] smp;
      logic                        trig_q;
      logic                        trig_d;
      logic                        edge_det;
      logic                        last_edge;
      logic                        tmo;
      state_t                      state_q;
      logic [CW-1:0]               cnt_q;
      logic [CW-1:0]               ecnt_q;
      logic [CW-1:0]               since_q;
      logic [CW-1:0]               per_q;
      logic [CW:0]                 ecnt_inc;
      logic [CW:0]                 since_inc;
      logic                        vld_q;
      logic                        to_q;
      logic                        sat_q;

      assign smp = s_axis_tdata[g*LANE_WIDTH +: ADC_WIDTH];

      always_comb begin
         trig_d = trig_q;
         if (s_axis_tvalid) begin
            if (smp > $signed(cfg_hi_thr)) begin
               trig_d = 1'b1;
            end else if (smp < $signed(cfg_lo_thr)) begin
               trig_d = 1'b0;
            end
         end
      end

      assign edge_det = cfg_edge ? (trig_q & ~trig_d)
                                 : (~trig_q & trig_d);

      // One extra bit keeps the compares safe when config shrinks mid-run
      assign ecnt_inc  = {1'b0, ecnt_q} + {1'b0, CONE};
      assign since_inc = {1'b0, since_q} + {1'b0, CONE};
      assign last_edge = ecnt_inc >= {1'b0, nmax};
      assign tmo       = (cfg_timeout != '0) &&
                         (since_inc >= {1'b0, cfg_timeout});

      always_ff @(posedge clk) begin
         if (!rst) begin
            trig_q  <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            ecnt_q  <= '0;
            since_q <= '0;
            per_q   <= '0;
            vld_q   <= 1'b0;
            to_q    <= 1'b0;
            sat_q   <= 1'b0;
         end else begin
            trig_q <= trig_d;
            vld_q  <= 1'b0;
            to_q   <= 1'b0;
            if (state_q == MEASURE) begin
               cnt_q   <= (cnt_q == CMAX) ? cnt_q : cnt_q + CONE;
               since_q <= (since_q == CMAX) ? since_q : since_q + CONE;
            end
            if (cfg_restart || !cfg_enable[g]) begin
               state_q <= IDLE;
               cnt_q   <= '0;
               ecnt_q  <= '0;
               since_q <= '0;
            end else if (edge_det) begin
               // Counters load 1 so they read cycles elapsed since the edge
               since_q <= CONE;
               if (state_q == IDLE) begin
                  state_q <= MEASURE;
                  cnt_q   <= CONE;
                  ecnt_q  <= '0;
               end else if (last_edge) begin
                  per_q  <= cnt_q;
                  vld_q  <= 1'b1;
                  sat_q  <= (cnt_q == CMAX);
                  cnt_q  <= CONE;
                  ecnt_q <= '0;
               end else begin
                  ecnt_q <= ecnt_inc[CW-1:0];
               end
            end else if (state_q == MEASURE && tmo) begin
               to_q    <= 1'b1;
               state_q <= IDLE;
               cnt_q   <= '0;
               ecnt_q  <= '0;
               since_q <= '0;
            end
         end
      end

      assign period_count[g*CW +: CW] = per_q;
      assign period_valid[g]          = vld_q;
      assign timeout_pulse[g]         = to_q;
      assign saturated[g]             = sat_q;
   end

endmodule

// File: tb/tb_freq_counter_mc.sv
// Bench for freq_counter_mc: scenario table, corner sequences and a
// randomized run, all checked cycle by cycle against an event-time model.
module tb_freq_counter_mc;

   localparam int NCH = 2;
   localparam int AW  = 14;
   localparam int LW  = 16;
   localparam int CW  = 32;
   localparam longint CMAXL = 64'hFFFF_FFFF;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic [NCH*LW-1:0]    s_axis_tdata = '0;
   logic                 s_axis_tvalid = 1'b0;
   logic [NCH*LW-1:0]    m_axis_tdata;
   logic                 m_axis_tvalid;
   logic [NCH-1:0]       cfg_enable = '1;
   logic                 cfg_restart = 1'b0;
   logic                 cfg_edge = 1'b0;
   logic [AW-1:0]        cfg_hi_thr = '0;
   logic [AW-1:0]        cfg_lo_thr = '0;
   logic [CW-1:0]        cfg_ncycles = '0;
   logic [CW-1:0]        cfg_timeout = '0;
   logic [NCH*CW-1:0]    period_count;
   logic [NCH-1:0]       period_valid;
   logic [NCH-1:0]       timeout_pulse;
   logic [NCH-1:0]       saturated;

   freq_counter_mc #(
      .NCH(NCH), .ADC_WIDTH(AW), .LANE_WIDTH(LW), .COUNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .cfg_enable(cfg_enable), .cfg_restart(cfg_restart),
      .cfg_edge(cfg_edge), .cfg_hi_thr(cfg_hi_thr),
      .cfg_lo_thr(cfg_lo_thr), .cfg_ncycles(cfg_ncycles),
      .cfg_timeout(cfg_timeout), .period_count(period_count),
      .period_valid(period_valid), .timeout_pulse(timeout_pulse),
      .saturated(saturated)
   );

   always #4 clk = ~clk;

   int nvec = 0;
   int nfail = 0;
   longint cyc = 0;

   // waveform sources: 0 square, 1 constant, 2 alternating -120/-130
   int     gmode[NCH];
   int     gper[NCH];
   int     ghi[NCH];
   int     gconst[NCH];
   longint gt0[NCH];
   int     tvmode = 0;

   // reference model: edge times, not counters
   bit     m_trig[NCH];
   bit     m_meas[NCH];
   longint m_ts[NCH];
   longint m_tl[NCH];
   longint m_ne[NCH];
   logic [CW-1:0] e_per[NCH];
   bit     e_vld[NCH];
   bit     e_to[NCH];
   bit     e_sat[NCH];

   int     o_vld[NCH];
   int     o_to[NCH];
   logic [CW-1:0] o_per[NCH];
   longint o_to_cyc[NCH];

   typedef struct {
      int per0; int hi0; int per1; int hi1;
      int ncyc; bit edg; int tvm; int exp0; int exp1;
   } vec_t;

   vec_t vt[5];

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int gen(int ch, longint t);
      longint rel;
      if (gmode[ch] == 0) begin
         rel = t - gt0[ch];
         if (rel < 0) rel = 0;
         return ((rel % gper[ch]) < ghi[ch]) ? 1000 : -1000;
      end else if (gmode[ch] == 2) begin
         return (t % 2 == 0) ? -120 : -130;
      end
      return gconst[ch];
   endfunction

   task automatic model();
      for (int ch = 0; ch < NCH; ch++) begin
         int sv; int hv; int lv;
         bit tn; bit ed;
         longint n; longint d;
         e_vld[ch] = 0;
         e_to[ch]  = 0;
         if (!rst) begin
            m_trig[ch] = 0; m_meas[ch] = 0;
            e_per[ch] = '0; e_sat[ch] = 0;
            continue;
         end
         sv = $signed(s_axis_tdata[ch*LW +: AW]);
         hv = $signed(cfg_hi_thr);
         lv = $signed(cfg_lo_thr);
         tn = m_trig[ch];
         if (s_axis_tvalid) begin
            if (sv > hv) tn = 1;
            else if (sv < lv) tn = 0;
         end
         ed = cfg_edge ? (m_trig[ch] && !tn) : (!m_trig[ch] && tn);
         n = (cfg_ncycles == 0) ? 1 : longint'(cfg_ncycles);
         if (cfg_restart || !cfg_enable[ch]) begin
            m_meas[ch] = 0;
         end else if (ed) begin
            if (!m_meas[ch]) begin
               m_meas[ch] = 1; m_ts[ch] = cyc; m_tl[ch] = cyc; m_ne[ch] = 0;
            end else begin
               m_ne[ch]++;
               m_tl[ch] = cyc;
               if (m_ne[ch] >= n) begin
                  d = cyc - m_ts[ch];
                  e_per[ch] = CW'((d > CMAXL) ? CMAXL : d);
                  e_sat[ch] = (d >= CMAXL);
                  e_vld[ch] = 1;
                  m_ts[ch] = cyc;
                  m_ne[ch] = 0;
               end
            end
         end else if (m_meas[ch] && cfg_timeout != 0 &&
                      (cyc - m_tl[ch]) >= longint'(cfg_timeout) - 1) begin
            e_to[ch] = 1;
            m_meas[ch] = 0;
         end
         m_trig[ch] = tn;
      end
   endtask

   task automatic step();
      for (int ch = 0; ch < NCH; ch++) begin
         int v;
         v = gen(ch, cyc);
         s_axis_tdata[ch*LW +: LW] = LW'(v);
      end
      case (tvmode)
         1:       s_axis_tvalid = 1'($urandom % 2);
         2:       s_axis_tvalid = (cyc % 2 == 0);
         default: s_axis_tvalid = 1'b1;
      endcase
      model();
      @(posedge clk);
      #1;
      for (int ch = 0; ch < NCH; ch++) begin
         chk($sformatf("valid[%0d]@%0d", ch, cyc), period_valid[ch], e_vld[ch]);
         chk($sformatf("tmo[%0d]@%0d", ch, cyc), timeout_pulse[ch], e_to[ch]);
         chk($sformatf("sat[%0d]@%0d", ch, cyc), saturated[ch], e_sat[ch]);
         chk($sformatf("count[%0d]@%0d", ch, cyc),
             period_count[ch*CW +: CW], e_per[ch]);
         if (period_valid[ch]) begin
            o_vld[ch]++;
            o_per[ch] = period_count[ch*CW +: CW];
         end
         if (timeout_pulse[ch]) begin
            o_to[ch]++;
            o_to_cyc[ch] = cyc + 1;
         end
      end
      chk($sformatf("pass_data@%0d", cyc), m_axis_tdata, s_axis_tdata);
      chk($sformatf("pass_valid@%0d", cyc), m_axis_tvalid, s_axis_tvalid);
      cyc++;
   endtask

   task automatic run(int n);
      repeat (n) step();
   endtask

   task automatic clear_obs();
      for (int ch = 0; ch < NCH; ch++) begin
         o_vld[ch] = 0; o_to[ch] = 0; o_per[ch] = '0; o_to_cyc[ch] = -1;
      end
   endtask

   task automatic go_const(int v);
      for (int ch = 0; ch < NCH; ch++) begin
         gmode[ch] = 1; gconst[ch] = v;
      end
   endtask

   task automatic restart();
      cfg_restart = 1'b1;
      step();
      cfg_restart = 1'b0;
   endtask

   task automatic start_sq(int ch, int per, int hi);
      gmode[ch] = 0; gper[ch] = per; ghi[ch] = hi; gt0[ch] = cyc;
   endtask

   initial begin
      vt[0] = '{100, 50, 100, 50,  4, 1'b0, 0,  400,  400};
      vt[1] = '{100, 30, 100, 30,  1, 1'b1, 0,  100,  100};
      vt[2] = '{100, 30, 100, 70,  0, 1'b1, 0,  100,  100};
      vt[3] = '{100, 50,  37, 18, 10, 1'b0, 0, 1000,  370};
      vt[4] = '{200, 100, 200, 60, 1, 1'b0, 2,  200,  200};

      cfg_hi_thr = AW'(-100);
      cfg_lo_thr = AW'(-150);
      cfg_ncycles = 4;
      go_const(1000);
      clear_obs();

      rst = 1'b0;
      run(4);
      for (int ch = 0; ch < NCH; ch++)
         chk($sformatf("reset_count[%0d]", ch), period_count[ch*CW +: CW], 0);
      rst = 1'b1;
      go_const(-1000);
      run(4);

      for (int i = 0; i < 5; i++) begin
         int len;
         cfg_ncycles = vt[i].ncyc;
         cfg_edge    = vt[i].edg;
         cfg_timeout = 0;
         tvmode      = vt[i].tvm;
         go_const(-1000);
         restart();
         run(3);
         clear_obs();
         start_sq(0, vt[i].per0, vt[i].hi0);
         start_sq(1, vt[i].per1, vt[i].hi1);
         len = 2 * ((vt[i].exp0 > vt[i].exp1) ? vt[i].exp0 : vt[i].exp1)
               + 2 * vt[i].per0 + 20;
         run(len);
         chk($sformatf("v%0d_n0", i), o_vld[0] >= 2, 1);
         chk($sformatf("v%0d_n1", i), o_vld[1] >= 2, 1);
         chk($sformatf("v%0d_p0", i), o_per[0], vt[i].exp0);
         chk($sformatf("v%0d_p1", i), o_per[1], vt[i].exp1);
      end
      tvmode = 0;

      // reset in the middle of a measurement
      cfg_ncycles = 10;
      cfg_edge = 1'b0;
      go_const(-1000);
      restart();
      run(3);
      start_sq(0, 100, 50);
      start_sq(1, 37, 18);
      run(1500);
      rst = 1'b0;
      run(3);
      chk("mid_rst_cnt0", period_count[0 +: CW], 0);
      chk("mid_rst_cnt1", period_count[CW +: CW], 0);
      chk("mid_rst_valid", period_valid, 0);
      rst = 1'b1;
      clear_obs();
      run(2300);
      chk("post_rst_p0", o_per[0], 1000);
      chk("post_rst_p1", o_per[1], 370);

      // hysteresis band holds trig; a single step makes one edge
      begin
         longint ts;
         cfg_ncycles = 1;
         cfg_timeout = 20;
         go_const(-1000);
         restart();
         run(5);
         clear_obs();
         gmode[0] = 2;
         run(50);
         chk("band_tmo", o_to[0], 0);
         chk("band_vld", o_vld[0], 0);
         gmode[0] = 1; gconst[0] = 500;
         ts = cyc;
         run(40);
         chk("step_tmo", o_to[0], 1);
         chk("step_tmo_at", o_to_cyc[0], ts + 20);
         chk("step_vld", o_vld[0], 0);
      end

      // timeout keeps the previous result
      begin
         longint t0;
         cfg_ncycles = 1;
         cfg_timeout = 0;
         go_const(-1000);
         restart();
         run(3);
         start_sq(0, 100, 50);
         run(350);
         go_const(-1000);
         cfg_ncycles = 4;
         cfg_timeout = 500;
         restart();
         run(5);
         clear_obs();
         start_sq(0, 100, 50);
         t0 = cyc;
         run(150);
         gmode[0] = 1;
         run(600);
         chk("tmo_count", o_to[0], 1);
         chk("tmo_at", o_to_cyc[0], t0 + 600);
         chk("tmo_keep", period_count[0 +: CW], 100);
         chk("tmo_novld", o_vld[0], 0);
      end

      // randomized run against the model
      for (int r = 0; r < 4; r++) begin
         int hv;
         cfg_ncycles = $urandom_range(0, 4);
         cfg_edge    = 1'($urandom % 2);
         cfg_timeout = ($urandom % 2) ? 0 : $urandom_range(30, 400);
         hv          = $urandom_range(0, 1000) - 500;
         cfg_hi_thr  = AW'(hv);
         cfg_lo_thr  = AW'(hv - $urandom_range(0, 300) + 50);
         tvmode      = $urandom_range(0, 2);
         restart();
         for (int ch = 0; ch < NCH; ch++) begin
            int p;
            p = $urandom_range(20, 120);
            gmode[ch] = 0; gper[ch] = p;
            ghi[ch] = $urandom_range(1, p - 1);
            gt0[ch] = cyc + $urandom_range(0, 50);
         end
         for (int k = 0; k < 3000; k++) begin
            cfg_restart = ($urandom % 600 == 0);
            if ($urandom % 400 == 0)
               cfg_enable[$urandom % NCH] ^= 1'b1;
            step();
         end
         cfg_restart = 1'b0;
         cfg_enable = '1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/freq_counter_mc.md
Name: freq_counter_mc

Overview:
Multi-channel reciprocal frequency counter for Red Pitaya ADC streams. Each channel does the following:
- applies a runtime-programmable Schmitt trigger to its ADC lane;
- counts clk cycles across N signal periods;
- reports a period count with a one-cycle valid strobe;
- detects edge timeouts.

The AXI-Stream input is forwarded unchanged so the block can sit in-line between the ADC and downstream DSP/DMA.

Parameters:
NCH, 2, number of channels (1..8)
ADC_WIDTH, 14, signed sample width per channel
LANE_WIDTH, 16, bits per channel lane in tdata; channel i = tdata[i*LANE_WIDTH +: ADC_WIDTH]
COUNT_WIDTH, 32, width of the cycle counter, period result, cfg_ncycles and cfg_timeout

Ports:
clk  in  1  system clock (125 MHz)
rst  in  1  synchronous, active-low reset
s_axis_tdata  in  NCH*LANE_WIDTH  ADC samples
s_axis_tvalid  in  1  sample valid
m_axis_tdata  out  NCH*LANE_WIDTH  equals s_axis_tdata (combinational)
m_axis_tvalid  out  1  equals s_axis_tvalid (combinational)
cfg_enable  in  NCH  per-channel enable
cfg_restart  in  1  single-cycle pulse: all channels return to IDLE
cfg_edge  in  1  0 = rising edges counted, 1 = falling
cfg_hi_thr  in  ADC_WIDTH  signed upper threshold
cfg_lo_thr  in  ADC_WIDTH  signed lower threshold
cfg_ncycles  in  COUNT_WIDTH  signal periods per measurement; 0 treated as 1
cfg_timeout  in  COUNT_WIDTH  max clk cycles between consecutive edges; 0 = disabled
period_count  out  NCH*COUNT_WIDTH  last result per channel
period_valid  out  NCH  one-cycle strobe per new result
timeout_pulse  out  NCH  one-cycle strobe on timeout
saturated  out  NCH  sticky; counter hit all-ones in the last measurement

Behaviour:
- Reset: rst is synchronous and active-low, clocked by clk. While rst=0, every channel goes to:
  - trig=0, FSM=IDLE, counter=0, edge count=0;
  - period_count=0, period_valid=0, timeout_pulse=0, saturated=0.
- Reset mid-measurement aborts the measurement with no result.
- Schmitt trigger (per channel, updated only when s_axis_tvalid=1):
  - sample > hi_thr sets trig_next=1;
  - else sample < lo_thr sets trig_next=0;
  - else trig holds.
  - Signed compare. If hi_thr < lo_thr, the high test has priority. While tvalid=0, trig holds.
- Edge: the cycle where trig_next != trig in the selected direction (0->1 rising, 1->0 falling).
- FSM per channel: IDLE, MEASURE.
  - IDLE: counter held at 0. First edge with cfg_enable[i]=1 -> MEASURE, counter=0, edge count=0.
  - MEASURE: counter increments every clk (independent of tvalid) and saturates at all-ones.
    - Every edge increments the edge count.
    - On the Nth edge (N = max(cfg_ncycles,1)), the following happen simultaneously the next cycle:
      - period_count = clk cycles elapsed between start edge and Nth edge;
      - period_valid=1 for one cycle;
      - saturated updated;
      - counter restarts from 0 with this edge as the new start (no dead time), edge count=0.
    - Timeout: if cfg_timeout != 0 and cycles since the last edge reach cfg_timeout, then timeout_pulse=1 for one cycle, FSM -> IDLE, and period_count is unchanged.
    - If cfg_enable[i] drops, or cfg_restart=1, FSM -> IDLE with no result. cfg_restart has priority over an edge in the same cycle.
- Latency: period_valid is asserted exactly 1 clk after the cycle the final edge is detected.
- Config changes take effect immediately. Software must pulse cfg_restart after changing cfg_ncycles or cfg_edge; results spanning a change are undefined but must not hang the FSM.
- Channels are fully independent apart from the shared cfg_* inputs.

Test Plan:
1. Ch0 square wave (+1000/-1000), period 100 clk, thr -100/-150, ncycles=4 -> first period_valid 1 clk after the 5th rising edge, then every 400 clk; period_count=400 each time.
2. Samples alternating -120/-130 every cycle, then a step to +500 -> no period_valid and no trig change until the step; exactly one edge at the step.
3. cfg_edge=1, duty-cycle 30/70 period 100, ncycles=1 -> period_count=100 on each falling edge; with ncycles=0 the same result.
4. cfg_timeout=500, signal stops after 2 edges -> timeout_pulse exactly 500 clk after the last edge; FSM back in IDLE; period_count retains its previous value.
5. Ch0 period 100, ch1 period 37, ncycles=10 -> ch0 reports 1000 and ch1 reports 370 independently; rst=0 mid-measurement -> all outputs 0, and the next result needs a fresh start edge.
6. tvalid toggling 50% with a period-200-clk signal -> period_count=200 (counter counts clk, not samples); m_axis passthrough matches s_axis every cycle.
